// File: rtl/rf_pkg.sv
// Shared register-file constants and the writeback grant encoding.
package rf_pkg;

    localparam int REG_W  = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    // Age stamps only need to order the two live slots. Their distance stays
    // within about 2*(MAX_WAIT+2), so 8 bits with wrap-around compare is ample.
    localparam int STAMP_W = 8;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_LSU  = 2'd2
    } gnt_e;

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot: full flag, destination, data and age stamp.
module wb_slot
    import rf_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_valid,
    input  logic [ADDR_W-1:0]  i_addr,
    input  logic [REG_W-1:0]   i_data,
    input  logic [STAMP_W-1:0] i_stamp,
    input  logic               i_grant,
    output logic               o_ready,
    output logic               o_load,
    output logic               o_full,
    output logic [ADDR_W-1:0]  o_addr,
    output logic [REG_W-1:0]   o_data,
    output logic [STAMP_W-1:0] o_stamp
);

    logic               r_full;
    logic [ADDR_W-1:0]  r_addr;
    logic [REG_W-1:0]   r_data;
    logic [STAMP_W-1:0] r_stamp;
    logic               w_accept;

    // Ready comes only from slot state; writes to r0 are accepted but dropped.
    assign o_ready  = !r_full || i_grant;
    assign w_accept = i_valid && o_ready;
    assign o_load   = w_accept && (i_addr != '0);

    // Load on acceptance (overrides a same-edge drain), otherwise empty on grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_stamp <= '0;
        end else if (o_load) begin
            r_full  <= 1'b1;
            r_addr  <= i_addr;
            r_data  <= i_data;
            r_stamp <= i_stamp;
        end else if (i_grant) begin
            r_full  <= 1'b0;
        end
    end

    assign o_full  = r_full;
    assign o_addr  = r_addr;
    assign o_data  = r_data;
    assign o_stamp = r_stamp;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: two source slots, starvation-bounded
// LSU-first arbitration, same-address ordering by age, pending-write mask.
//
// Handshake: a source transfer happens on a rising edge where valid && ready.
// ready depends only on the slot (empty, or being drained this cycle), never
// on valid, so a source may hold valid with any payload until it sees ready.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [REG_W-1:0]  alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [REG_W-1:0]  lsu_data,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              wrt_en,
    output logic [ADDR_W-1:0] wrt_addr,
    output logic [REG_W-1:0]  dataD,
    output logic [NREG-1:0]   pend_mask
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0]  r_alu_wait;
    logic [STAMP_W-1:0] r_seq;
    logic [NREG-1:0]    r_pend_mask;

    logic               w_alu_load, w_alu_full, w_lsu_load, w_lsu_full;
    logic [ADDR_W-1:0]  w_alu_addr, w_lsu_addr;
    logic [REG_W-1:0]   w_alu_data, w_lsu_data;
    logic [STAMP_W-1:0] w_alu_stamp, w_lsu_stamp, w_alu_in_stamp, w_stamp_diff;
    logic               w_alu_older;
    gnt_e               w_gnt;
    logic [NREG-1:0]    w_pend_next;

    // For same-edge acceptance the LSU takes the lower stamp, i.e. is older.
    assign w_alu_in_stamp = r_seq + STAMP_W'(w_lsu_load);
    assign w_stamp_diff   = w_alu_stamp - w_lsu_stamp;
    assign w_alu_older    = w_stamp_diff[STAMP_W-1];

    wb_slot u_alu_slot (
        .clk     (clk),
        .reset   (reset),
        .i_valid (alu_valid),
        .i_addr  (alu_addr),
        .i_data  (alu_data),
        .i_stamp (w_alu_in_stamp),
        .i_grant (w_gnt == GNT_ALU),
        .o_ready (alu_ready),
        .o_load  (w_alu_load),
        .o_full  (w_alu_full),
        .o_addr  (w_alu_addr),
        .o_data  (w_alu_data),
        .o_stamp (w_alu_stamp)
    );

    wb_slot u_lsu_slot (
        .clk     (clk),
        .reset   (reset),
        .i_valid (lsu_valid),
        .i_addr  (lsu_addr),
        .i_data  (lsu_data),
        .i_stamp (r_seq),
        .i_grant (w_gnt == GNT_LSU),
        .o_ready (lsu_ready),
        .o_load  (w_lsu_load),
        .o_full  (w_lsu_full),
        .o_addr  (w_lsu_addr),
        .o_data  (w_lsu_data),
        .o_stamp (w_lsu_stamp)
    );

    // Grant: sole full slot; same address -> older; else LSU unless ALU starved.
    always_comb begin
        w_gnt = GNT_NONE;
        if (w_alu_full && w_lsu_full) begin
            if (w_alu_addr == w_lsu_addr)
                w_gnt = w_alu_older ? GNT_ALU : GNT_LSU;
            else if (r_alu_wait == WAIT_W'(MAX_WAIT))
                w_gnt = GNT_ALU;
            else
                w_gnt = GNT_LSU;
        end else if (w_alu_full) begin
            w_gnt = GNT_ALU;
        end else if (w_lsu_full) begin
            w_gnt = GNT_LSU;
        end
    end

    // Register-file write port driven straight from the granted slot.
    always_comb begin
        wrt_en   = 1'b0;
        wrt_addr = '0;
        dataD    = '0;
        if (w_gnt == GNT_ALU) begin
            wrt_en   = 1'b1;
            wrt_addr = w_alu_addr;
            dataD    = w_alu_data;
        end else if (w_gnt == GNT_LSU) begin
            wrt_en   = 1'b1;
            wrt_addr = w_lsu_addr;
            dataD    = w_lsu_data;
        end
    end

    // Count cycles the ALU slot loses arbitration, saturating at MAX_WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alu_wait <= '0;
        end else if (w_gnt == GNT_ALU) begin
            r_alu_wait <= '0;
        end else if (w_alu_full && (r_alu_wait != WAIT_W'(MAX_WAIT))) begin
            r_alu_wait <= r_alu_wait + WAIT_W'(1);
        end
    end

    // Age sequence advances by the number of slots loaded this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_seq <= '0;
        else
            r_seq <= r_seq + STAMP_W'(w_lsu_load) + STAMP_W'(w_alu_load);
    end

    // Pending mask: clear on write, then set on issue so a same-edge set wins.
    always_comb begin
        w_pend_next = r_pend_mask;
        if (wrt_en)
            w_pend_next[wrt_addr] = 1'b0;
        if (iss_valid && (iss_addr != '0))
            w_pend_next[iss_addr] = 1'b1;
        w_pend_next[0] = 1'b0;
    end

    // Register the pending mask.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_pend_mask <= '0;
        else
            r_pend_mask <= w_pend_next;
    end

    assign pend_mask = r_pend_mask;

endmodule
